// File: rtl/shared_reg_arbiter.sv
// ---------------------------------------------------------------------------
// shared_reg_arbiter
//   Round-robin arbiter and write sequencer for one shared DATA_W-bit storage
//   register that is contended by NUM_REQ requesters. One requester is picked
//   per transaction. Its grant is pulsed for one cycle, its data lane is
//   loaded into the register, and its index is reported as the owner.
//
//   Optional feature macro: SHARED_REG_LOCK_EN
//     Adds a LOCKED state. The current owner keeps exclusive use of the
//     register while it holds its lock bit. When the macro is undefined, the
//     lock input is ignored and arbitration is pure round-robin.
//
// Ports
//   clk      in   1                clock, all logic on posedge
//   reset    in   1                synchronous, active-high
//   req      in   NUM_REQ          per-requester write request (level)
//   wdata    in   NUM_REQ*DATA_W   lane i = wdata[i*DATA_W +: DATA_W]
//   lock     in   NUM_REQ          ownership hold (lock build only)
//   gnt      out  NUM_REQ          one-hot grant, high only in the WRITE cycle
//   q        out  DATA_W           shared register contents
//   q_valid  out  1                set once any write has completed
//   owner    out  $clog2(NUM_REQ)  index of last/current granted requester
// ---------------------------------------------------------------------------
module shared_reg_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  wdata,
  input  logic [NUM_REQ-1:0]         lock,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [DATA_W-1:0]          q,
  output logic                       q_valid,
  output logic [$clog2(NUM_REQ)-1:0] owner
);

  localparam int OW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1
`ifdef SHARED_REG_LOCK_EN
    ,
    ST_LOCKED = 2'd2
`endif
  } state_t;

  state_t              state_r;
  state_t              next_state_s;
  logic [OW-1:0]       owner_r;
  logic [OW-1:0]       next_owner_s;
  logic [OW-1:0]       rr_ptr_r;
  logic [DATA_W-1:0]   q_r;
  logic                q_valid_r;
  logic [NUM_REQ-1:0]  gnt_r;
  logic [NUM_REQ-1:0]  gnt_next_s;
  logic                load_s;
  logic [DATA_W-1:0]   lane_s [NUM_REQ];

`ifndef SHARED_REG_LOCK_EN
  // The lock input has no function in this build.
  logic unused_lock_s;
  assign unused_lock_s = ^lock;
`endif

  // Round-robin pick: first set request scanning ptr, ptr+1, ... mod NUM_REQ.
  // The sum is one bit wider than OW so it cannot overflow before the wrap.
  function automatic logic [OW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                            input logic [OW-1:0]      ptr);
    logic [OW-1:0] win;
    logic [OW:0]   sum;
    logic          found;
    win   = ptr;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + (OW+1)'(i);
      if (sum >= (OW+1)'(NUM_REQ)) begin
        sum = sum - (OW+1)'(NUM_REQ);
      end
      if (!found && r[sum[OW-1:0]]) begin
        win   = sum[OW-1:0];
        found = 1'b1;
      end
    end
    return win;
  endfunction

  // Split the packed write-data bus into per-requester lanes.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign lane_s[g] = wdata[g*DATA_W +: DATA_W];
  end

  // Next-state, next-owner and write-enable decode.
  always_comb begin
    next_state_s = state_r;
    next_owner_s = owner_r;
    load_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req != {NUM_REQ{1'b0}}) begin
          next_owner_s = rr_pick(req, rr_ptr_r);
          next_state_s = ST_WRITE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        load_s = 1'b1;
`ifdef SHARED_REG_LOCK_EN
        if (lock[owner_r]) begin
          next_state_s = ST_LOCKED;
        end else begin
          next_state_s = ST_IDLE;
        end
`else
        next_state_s = ST_IDLE;
`endif
      end
`ifdef SHARED_REG_LOCK_EN
      ST_LOCKED: begin
        // Only the owner may re-enter WRITE; everyone else waits.
        if (lock[owner_r]) begin
          if (req[owner_r]) begin
            next_state_s = ST_WRITE;
          end else begin
            next_state_s = ST_LOCKED;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
`endif
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
    // The grant is registered. It is high exactly while the state is WRITE.
    if (next_state_s == ST_WRITE) begin
      gnt_next_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << next_owner_s;
    end else begin
      gnt_next_s = {NUM_REQ{1'b0}};
    end
  end

  // State, owner, pointer, grant and shared-register update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      owner_r   <= {OW{1'b0}};
      rr_ptr_r  <= {OW{1'b0}};
      q_r       <= {DATA_W{1'b0}};
      q_valid_r <= 1'b0;
      gnt_r     <= {NUM_REQ{1'b0}};
    end else begin
      state_r <= next_state_s;
      owner_r <= next_owner_s;
      gnt_r   <= gnt_next_s;
      if (load_s) begin
        q_r       <= lane_s[owner_r];
        q_valid_r <= 1'b1;
        rr_ptr_r  <= (owner_r == OW'(NUM_REQ-1)) ? {OW{1'b0}} : owner_r + OW'(1);
      end
    end
  end

  assign gnt     = gnt_r;
  assign q       = q_r;
  assign q_valid = q_valid_r;
  assign owner   = owner_r;

endmodule
